// File: rtl/skolem_ashr_uge_sweep_checker.sv
// -----------------------------------------------------------------------------
// skolem_ashr_uge_sweep_checker
//
// Consumer-side harness for the bvuge/bvashr Skolem witness block. It walks
// every (s,t) operand pair and hands each one to the witness block. It then
// collects the witness x and checks (s >>> x) >=u t whenever the
// invertibility condition IC = s[W-1] | (s >=u t) holds. Each vector bumps
// exactly one of pass/fail/vacuous, so the three counters add up to 2^(2W)
// when the sweep is done.
//
// Ports
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   start              pulse; begins a sweep from IDLE or DONE
//   req_valid/ready    request handshake towards the witness block
//   req_s, req_t       operands of the current vector (index = {s,t})
//   rsp_valid, rsp_x   witness response; only observed while waiting
//   busy, done         sweep in progress / sweep complete (held until start)
//   pass_cnt           IC holds and the witness is correct
//   fail_cnt           IC holds and the witness is wrong, or no response came
//   vac_cnt            IC false, witness ignored
//   timeout            sticky; a response wait ran out
//
// Optional feature (macro FAIL_CAPTURE_EN):
//   first_fail_vld, first_fail_s, first_fail_t, first_fail_x latch the
//   first failing vector of a sweep (x reads 0 for a timed-out vector).
//
// Parameters: W operand width, TIMEOUT response wait limit in cycles,
// CNT_W counter width (counters saturate at all ones).
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_ISSUE | req_valid high, holding {s,t} until accepted
// S_WAIT  | request accepted, waiting for rsp_valid with a down-counter timer
// S_EVAL  | classify the vector, bump one counter, step the index
// S_DONE  | all vectors processed, done high until the next start
// -----------------------------------------------------------------------------
module skolem_ashr_uge_sweep_checker #(
  parameter int W       = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [W-1:0]     req_s,
  output logic [W-1:0]     req_t,
  input  logic             rsp_valid,
  input  logic [W-1:0]     rsp_x,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vac_cnt,
  output logic             timeout
`ifdef FAIL_CAPTURE_EN
  ,
  output logic             first_fail_vld,
  output logic [W-1:0]     first_fail_s,
  output logic [W-1:0]     first_fail_t,
  output logic [W-1:0]     first_fail_x
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EVAL,
    S_DONE
  } state_t;

  // The timer is loaded with TIMEOUT-1 on accept and expires when it hits
  // zero without a response, which gives exactly TIMEOUT cycles in S_WAIT.
  localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [W-1:0]     SH_SAT   = W'(W - 1);

  state_t           state;
  logic [2*W-1:0]   idx;
  logic [W-1:0]     x_r;
  logic             to_r;
  logic [TMR_W-1:0] tmr;

  logic [W-1:0]     ev_a;
  logic             ev_ic;
  logic             ev_ok;
  logic             ev_fail;
  logic             ev_vac;

  // Shifts of W-1 or more leave only copies of the sign bit.
  function automatic logic [W-1:0] ashr_sat(input logic [W-1:0] v,
                                            input logic [W-1:0] sh);
    if (sh >= SH_SAT) begin
      return {W{v[W-1]}};
    end
    return $signed(v) >>> sh;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // The operands come straight from the index. The index only moves in
  // S_EVAL, so the request stays stable while it is stalled.
  assign req_s = idx[2*W-1:W];
  assign req_t = idx[W-1:0];

  always_comb begin
    ev_a    = ashr_sat(req_s, x_r);
    ev_ic   = req_s[W-1] | (req_s >= req_t);
    ev_ok   = (ev_a >= req_t);
    // A timed-out vector is a fail regardless of IC.
    ev_fail = to_r | (ev_ic & ~ev_ok);
    ev_vac  = ~to_r & ~ev_ic;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      x_r       <= '0;
      to_r      <= 1'b0;
      tmr       <= '0;
      req_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      vac_cnt   <= '0;
      timeout   <= 1'b0;
`ifdef FAIL_CAPTURE_EN
      first_fail_vld <= 1'b0;
      first_fail_s   <= '0;
      first_fail_t   <= '0;
      first_fail_x   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_ISSUE;
            idx       <= '0;
            to_r      <= 1'b0;
            req_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            vac_cnt   <= '0;
            timeout   <= 1'b0;
`ifdef FAIL_CAPTURE_EN
            first_fail_vld <= 1'b0;
            first_fail_s   <= '0;
            first_fail_t   <= '0;
            first_fail_x   <= '0;
`endif
          end
        end

        S_ISSUE: begin
          if (req_ready) begin
            state     <= S_WAIT;
            req_valid <= 1'b0;
            tmr       <= TMR_LOAD;
          end
        end

        S_WAIT: begin
          if (rsp_valid) begin
            state <= S_EVAL;
            x_r   <= rsp_x;
            to_r  <= 1'b0;
          end else if (tmr == '0) begin
            state   <= S_EVAL;
            x_r     <= '0;
            to_r    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        S_EVAL: begin
          if (ev_fail) begin
            fail_cnt <= sat_inc(fail_cnt);
`ifdef FAIL_CAPTURE_EN
            if (!first_fail_vld) begin
              first_fail_vld <= 1'b1;
              first_fail_s   <= req_s;
              first_fail_t   <= req_t;
              first_fail_x   <= x_r;
            end
`endif
          end else if (ev_vac) begin
            vac_cnt <= sat_inc(vac_cnt);
          end else begin
            pass_cnt <= sat_inc(pass_cnt);
          end

          if (&idx) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= S_ISSUE;
            idx       <= idx + 1'b1;
            req_valid <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          req_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_ashr_uge_sweep_checker.sv
module tb_skolem_ashr_uge_sweep_checker;

  localparam int W     = 4;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             req_valid;
  logic             req_ready;
  logic [W-1:0]     req_s;
  logic [W-1:0]     req_t;
  logic             rsp_valid;
  logic [W-1:0]     rsp_x;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] vac_cnt;
  logic             timeout;
`ifdef FAIL_CAPTURE_EN
  logic             first_fail_vld;
  logic [W-1:0]     first_fail_s;
  logic [W-1:0]     first_fail_t;
  logic [W-1:0]     first_fail_x;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: 0 = pass, 1 = fail, 2 = vacuous
  int exp_q[$];
  int exp_p, exp_f, exp_v;

  bit         ovr_en[256];
  logic [3:0] ovr_x[256];
  int         mute_idx = -1;

  always #5 clk = ~clk;

  skolem_ashr_uge_sweep_checker #(.W(W), .TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_s     (req_s),
    .req_t     (req_t),
    .rsp_valid (rsp_valid),
    .rsp_x     (rsp_x),
    .busy      (busy),
    .done      (done),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .vac_cnt   (vac_cnt),
    .timeout   (timeout)
`ifdef FAIL_CAPTURE_EN
    ,
    .first_fail_vld (first_fail_vld),
    .first_fail_s   (first_fail_s),
    .first_fail_t   (first_fail_t),
    .first_fail_x   (first_fail_x)
`endif
  );

  // reference shift: one sign-filling step at a time
  function automatic logic [3:0] m_ashr(input logic [3:0] s, input logic [3:0] x);
    logic [3:0] r;
    r = s;
    for (int i = 0; i < int'(x); i++) r = {r[3], r[3:1]};
    return r;
  endfunction

  function automatic int exp_cat(input logic [3:0] s, input logic [3:0] t,
                                 input logic [3:0] x);
    logic ic;
    ic = s[3] | (s >= t);
    if (!ic) return 2;
    if (m_ashr(s, x) >= t) return 0;
    return 1;
  endfunction

  function automatic logic [3:0] witness(input logic [3:0] s, input logic [3:0] t);
    for (int i = 0; i < 16; i++) begin
      if (m_ashr(s, 4'(i)) >= t) return 4'(i);
    end
    return 4'($urandom_range(15));
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives one sweep from the current negedge: responder, scoreboard and
  // end-of-sweep totals. abort_at/start_at < 0 disables those events.
  task automatic run_sweep(input int stall_pct, input bit spurious, input int abort_at,
                           input int start_at, input bit exp_to, output bit aborted);
    int               cyc;
    bit               resp_due;
    logic [3:0]       resp_x_n;
    int               acc_cyc;
    bit               to_seen;
    logic [CNT_W-1:0] pp, pf, pv;
    bit               prev_stall;
    logic [7:0]       prev_idx;
    logic [7:0]       ix;
    logic [3:0]       x;
    int               act, e;
    bit               finished;
    cyc = 0; resp_due = 0; resp_x_n = '0; acc_cyc = -1; to_seen = 0;
    pp = '0; pf = '0; pv = '0; prev_stall = 0; prev_idx = '0;
    aborted = 0; finished = 0;
    exp_q.delete(); exp_p = 0; exp_f = 0; exp_v = 0;
    while (!finished) begin
      if (pass_cnt !== pp || fail_cnt !== pf || vac_cnt !== pv) begin
        if (pass_cnt == pp + 1 && fail_cnt == pf && vac_cnt == pv) act = 0;
        else if (pass_cnt == pp && fail_cnt == pf + 1 && vac_cnt == pv) act = 1;
        else if (pass_cnt == pp && fail_cnt == pf && vac_cnt == pv + 1) act = 2;
        else act = -1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: counter update %0d with no vector outstanding", act);
        end else begin
          e = exp_q.pop_front();
          if (act != e) begin
            n_fail++;
            $display("FAIL sb_category: vector result %0d, expected %0d (p=%0d f=%0d v=%0d)",
                     act, e, pass_cnt, fail_cnt, vac_cnt);
          end
        end
        pp = pass_cnt; pf = fail_cnt; pv = vac_cnt;
      end

      if (prev_stall) begin
        n_checks++;
        if (req_valid !== 1'b1 || {req_s, req_t} !== prev_idx) begin
          n_fail++;
          $display("FAIL req_stable: valid=%b idx=%h, required valid=1 idx=%h",
                   req_valid, {req_s, req_t}, prev_idx);
        end
      end

      if (acc_cyc >= 0 && !to_seen && timeout === 1'b1) begin
        to_seen = 1;
        n_checks++;
        if (cyc - acc_cyc != 16) begin
          n_fail++;
          $display("FAIL timeout_latency: seen %0d cycles after accept, expected 16",
                   cyc - acc_cyc);
        end
      end

      if (done === 1'b1) begin
        finished = 1;
      end else if (cyc >= 20000) begin
        n_checks++; n_fail++;
        $display("FAIL sweep_bound: no done after %0d cycles", cyc);
        finished = 1;
      end else if (abort_at >= 0 && req_valid === 1'b1 && {req_s, req_t} == 8'(abort_at)) begin
        n_checks++;
        if (32'(pass_cnt) + 32'(fail_cnt) + 32'(vac_cnt) != abort_at) begin
          n_fail++;
          $display("FAIL partial_sum: %0d before abort, expected %0d",
                   32'(pass_cnt) + 32'(fail_cnt) + 32'(vac_cnt), abort_at);
        end
        rst_n = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({pass_cnt, fail_cnt, vac_cnt} !== '0 || {busy, done, timeout, req_valid} !== 4'b0 ||
            {req_s, req_t} !== 8'h00) begin
          n_fail++;
          $display("FAIL abort_reset: p=%0d f=%0d v=%0d busy=%b done=%b to=%b rv=%b idx=%h, required all 0",
                   pass_cnt, fail_cnt, vac_cnt, busy, done, timeout, req_valid, {req_s, req_t});
        end
        rst_n = 1'b1;
        exp_q.delete();
        aborted = 1;
        return;
      end else begin
        rsp_valid = 1'b0;
        start = (start_at >= 0 && req_valid === 1'b1 && {req_s, req_t} == 8'(start_at));
        if (resp_due) begin
          rsp_valid = 1'b1; rsp_x = resp_x_n; resp_due = 0;
        end
        req_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
        prev_stall = 0;
        if (req_valid === 1'b1) begin
          ix = {req_s, req_t};
          if (!req_ready) begin
            prev_stall = 1; prev_idx = ix;
            if (spurious && $urandom_range(3) == 0) begin
              rsp_valid = 1'b1; rsp_x = 4'($urandom_range(15));
            end
          end else if (int'(ix) == mute_idx) begin
            exp_q.push_back(1); exp_f++; acc_cyc = cyc;
          end else begin
            x = ovr_en[ix] ? ovr_x[ix] : witness(req_s, req_t);
            resp_due = 1; resp_x_n = x;
            e = exp_cat(req_s, req_t, x);
            exp_q.push_back(e);
            if (e == 0) exp_p++; else if (e == 1) exp_f++; else exp_v++;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; rsp_valid = 1'b0;

    n_checks++;
    if (int'(pass_cnt) != exp_p || int'(fail_cnt) != exp_f || int'(vac_cnt) != exp_v) begin
      n_fail++;
      $display("FAIL totals: p/f/v=%0d/%0d/%0d, expected %0d/%0d/%0d",
               pass_cnt, fail_cnt, vac_cnt, exp_p, exp_f, exp_v);
    end
    n_checks++;
    if (32'(pass_cnt) + 32'(fail_cnt) + 32'(vac_cnt) != 256) begin
      n_fail++;
      $display("FAIL total_sum: %0d, expected 256", 32'(pass_cnt) + 32'(fail_cnt) + 32'(vac_cnt));
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d vectors never counted, expected 0", exp_q.size());
    end
    n_checks++;
    if ({busy, req_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL done_state: busy=%b req_valid=%b, required 0 0", busy, req_valid);
    end
    n_checks++;
    if (timeout !== exp_to) begin
      n_fail++;
      $display("FAIL timeout_flag: %b, expected %b", timeout, exp_to);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_x = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_valid, busy, done, timeout} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: rv=%b busy=%b done=%b to=%b, required 0", req_valid, busy, done, timeout);
    end
    n_checks++;
    if ({pass_cnt, fail_cnt, vac_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: p=%0d f=%0d v=%0d, required 0", pass_cnt, fail_cnt, vac_cnt);
    end
    n_checks++;
    if ({req_s, req_t} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_index: %h, required 00", {req_s, req_t});
    end
`ifdef FAIL_CAPTURE_EN
    n_checks++;
    if (first_fail_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_fail: vld=%b, required 0", first_fail_vld);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, req_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_hold: busy=%b rv=%b without start, required 0 0", busy, req_valid);
    end
  endtask

  task automatic test_correct_sweep();
    bit ab;
    pulse_start();
    run_sweep(0, 0, -1, -1, 1'b0, ab);
    n_checks++;
    if (fail_cnt !== '0) begin
      n_fail++;
      $display("FAIL correct_fail_cnt: %0d, required 0", fail_cnt);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_held: %b, required 1", done);
    end
`ifdef FAIL_CAPTURE_EN
    n_checks++;
    if (first_fail_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL correct_first_fail: vld=%b, required 0", first_fail_vld);
    end
`endif
  endtask

  task automatic test_directed_vectors();
    bit ab;
    ovr_en[8'h8F] = 1; ovr_x[8'h8F] = 4'd3;   // a = 4'hF >=u F: pass
    ovr_en[8'h53] = 1; ovr_x[8'h53] = 4'd2;   // a = 1 <u 3: fail
    ovr_en[8'h56] = 1; ovr_x[8'h56] = 4'd7;   // IC = 0: vacuous
    pulse_start();
    run_sweep(0, 0, -1, -1, 1'b0, ab);
    n_checks++;
    if (fail_cnt !== 9'd1) begin
      n_fail++;
      $display("FAIL directed_fail_cnt: %0d, required 1", fail_cnt);
    end
`ifdef FAIL_CAPTURE_EN
    n_checks++;
    if ({first_fail_vld, first_fail_s, first_fail_t, first_fail_x} !== {1'b1, 4'h5, 4'h3, 4'h2}) begin
      n_fail++;
      $display("FAIL directed_first_fail: vld=%b s=%h t=%h x=%h, required 1 5 3 2",
               first_fail_vld, first_fail_s, first_fail_t, first_fail_x);
    end
`endif
    ovr_en[8'h8F] = 0; ovr_en[8'h53] = 0; ovr_en[8'h56] = 0;
  endtask

  task automatic test_timeout();
    bit ab;
    mute_idx = 8'h37;
    pulse_start();
    n_checks++;
    if ({busy, done, timeout} !== 3'b100) begin
      n_fail++;
      $display("FAIL start_from_done: busy=%b done=%b to=%b, required 1 0 0", busy, done, timeout);
    end
    run_sweep(0, 0, -1, -1, 1'b1, ab);
    n_checks++;
    if (fail_cnt !== 9'd1) begin
      n_fail++;
      $display("FAIL timeout_fail_cnt: %0d, required 1", fail_cnt);
    end
`ifdef FAIL_CAPTURE_EN
    n_checks++;
    if ({first_fail_vld, first_fail_s, first_fail_t, first_fail_x} !== {1'b1, 4'h3, 4'h7, 4'h0}) begin
      n_fail++;
      $display("FAIL timeout_first_fail: vld=%b s=%h t=%h x=%h, required 1 3 7 0",
               first_fail_vld, first_fail_s, first_fail_t, first_fail_x);
    end
`endif
    mute_idx = -1;
  endtask

  task automatic test_abort_restart();
    bit ab;
    pulse_start();
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL start_clears_timeout: %b, required 0", timeout);
    end
    run_sweep(30, 1, 100, -1, 1'b0, ab);
    n_checks++;
    if (ab !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reached: %b, required 1", ab);
    end
    repeat (2) @(negedge clk);
    pulse_start();
    run_sweep(30, 1, -1, 50, 1'b0, ab);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done: %b, required 1", done);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ovr_en[i] = 0; ovr_x[i] = '0;
    end
    @(negedge clk);
    test_reset();
    test_correct_sweep();
    test_directed_vectors();
    test_timeout();
    test_abort_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
